// File: rtl/fix_pkg.sv
// Shared fixed-point definitions for the fix_* blocks: fixu function codes,
// unity code derived from the fixnum fractional width, and FIR sequencer states.
`ifndef FIXWID
`define FIXWID 16
`endif
`ifndef FIXFRAC
`define FIXFRAC 12
`endif

package fix_pkg;

  localparam int unsigned FIX_W    = `FIXWID;
  localparam int unsigned FIX_FRAC = `FIXFRAC;

  localparam logic FN_MAC = 1'b0;
  localparam logic FN_SDC = 1'b1;

  localparam logic [FIX_W-1:0] FIX_ONE = FIX_W'(1 << FIX_FRAC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fix_fir_seq_if.sv
// Sample-in / result-out streams plus coefficient write port of fix_fir_seq.
// slave = the sequencer, master = upstream/downstream/host side.
interface fix_fir_seq_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 3
);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [W-1:0]  coef_wdata;
  logic          coef_ready;

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, out_ovf, coef_ready
  );

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, out_ovf, coef_ready
  );

endinterface

// File: rtl/fix_toggle_req.sv
// Toggle req/ack handshake initiator: flips req on each issue and tracks the
// last ack phase seen, flagging an ack whenever the ack line differs from it.
module fix_toggle_req (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic issue_i,
  input  logic ack_i,
  output logic req_o,
  output logic ack_pulse_o
);

  logic req_q;
  logic ack_seen_q;

  // Every ack edge is absorbed, so stray toggles simply resync the phase.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q      <= 1'b0;
      ack_seen_q <= 1'b0;
    end else if (enable) begin
      if (issue_i) req_q <= ~req_q;
      ack_seen_q <= ack_i;
    end
  end

  assign req_o       = req_q;
  assign ack_pulse_o = ack_i ^ ack_seen_q;

endmodule

// File: rtl/fix_fir_seq.sv
// Sample-rate FIR sequencer driving fixu with one MAC per tap.
// Optional watchdog on the fixu ack enabled by defining FIX_FIR_SEQ_TIMEOUT_EN.
module fix_fir_seq
  import fix_pkg::*;
#(
  parameter int unsigned TAPS = 8,
  parameter int unsigned W    = FIX_W
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
  , parameter int unsigned TMO = 1023
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  fix_fir_seq_if.slave        bus,
  output logic                fixu_req,
  input  logic                fixu_ack,
  output logic                fixu_fn,
  output logic [W-1:0]        fixu_a,
  output logic [W-1:0]        fixu_b,
  output logic [W-1:0]        fixu_c,
  input  logic [W-1:0]        fixu_z,
  input  logic                fixu_overflow
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
  , output logic              tmo_err
`endif
);

  localparam int unsigned    AW     = $clog2(TAPS);
  localparam logic [AW-1:0]  K_LAST = AW'(TAPS - 1);
  localparam logic [AW:0]    TAPS_C = (AW + 1)'(TAPS);

  fir_state_e     state_q;
  logic [W-1:0]   x_q [TAPS];
  logic [W-1:0]   h_q [TAPS];
  logic [AW-1:0]  k_q;
  logic [W-1:0]   acc_q;
  logic           ovf_q;
  logic [W-1:0]   a_q, b_q, c_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           out_ovf_q;
  logic           ack_pulse;
  logic           coef_wr;

`ifdef FIX_FIR_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);
  logic [15:0] wdog_q;
  logic        tmo_err_q;
`endif

  fix_toggle_req u_req (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .issue_i     (state_q == ISSUE),
    .ack_i       (fixu_ack),
    .req_o       (fixu_req),
    .ack_pulse_o (ack_pulse)
  );

  assign coef_wr = bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_C);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
      k_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
      wdog_q      <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else if (enable) begin
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
      tmo_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          // Coefficients are only read from ISSUE on, so a write in the same
          // cycle as the sample transfer already applies to that sample.
          if (coef_wr) h_q[bus.coef_addr] <= bus.coef_wdata;
          if (bus.in_valid) begin
            for (int unsigned i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            x_q[0]  <= bus.in_data;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            state_q <= ISSUE;
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        ISSUE: begin
          a_q     <= x_q[k_q];
          b_q     <= h_q[k_q];
          c_q     <= acc_q;
          state_q <= WAIT;
        end
        WAIT: begin
          if (ack_pulse) begin
            acc_q <= fixu_z;
            ovf_q <= ovf_q | fixu_overflow;
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
            wdog_q <= '0;
`endif
            if (k_q == K_LAST) begin
              out_valid_q <= 1'b1;
              out_data_q  <= fixu_z;
              out_ovf_q   <= ovf_q | fixu_overflow;
              state_q     <= OUT;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= ISSUE;
            end
          end
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
          else if (wdog_q == TMO_LAST) begin
            wdog_q      <= '0;
            tmo_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b1;
            state_q     <= OUT;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
`endif
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE) & enable;
  assign bus.coef_ready = (state_q == IDLE) & enable;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ovf    = out_ovf_q;

  assign fixu_fn = FN_MAC;
  assign fixu_a  = a_q;
  assign fixu_b  = b_q;
  assign fixu_c  = c_q;

`ifdef FIX_FIR_SEQ_TIMEOUT_EN
  assign tmo_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_fix_fir_seq.sv
// Directed bench for fix_fir_seq with TAPS = 4 and a saturating fixu model.
`timescale 1ns/1ps
module tb_fix_fir_seq;
  import fix_pkg::*;

  localparam int unsigned TAPS = 4;
  localparam int unsigned W    = FIX_W;
  localparam int unsigned AW   = 2;
  localparam int unsigned LAT  = 2;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  fix_fir_seq_if #(.W(W), .AW(AW)) bus ();

  logic         fixu_req, fixu_ack, fixu_fn, fixu_overflow;
  logic [W-1:0] fixu_a, fixu_b, fixu_c, fixu_z;
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
  logic         tmo_err;
`endif

  fix_fir_seq #(.TAPS(TAPS), .W(W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .bus           (bus),
    .fixu_req      (fixu_req),
    .fixu_ack      (fixu_ack),
    .fixu_fn       (fixu_fn),
    .fixu_a        (fixu_a),
    .fixu_b        (fixu_b),
    .fixu_c        (fixu_c),
    .fixu_z        (fixu_z),
    .fixu_overflow (fixu_overflow)
`ifdef FIX_FIR_SEQ_TIMEOUT_EN
    , .tmo_err     (tmo_err)
`endif
  );

  // fixu model: saturating z = ((a*b) >>> FRAC) + c, acked LAT cycles after req.
  function automatic logic [W:0] fixu_mac(input logic [W-1:0] a, b, c);
    longint p, s, maxv, minv;
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -maxv - 1;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> FIX_FRAC;
    s = p + longint'($signed(c));
    if (s > maxv) return {1'b1, W'(maxv)};
    if (s < minv) return {1'b1, W'(minv)};
    return {1'b0, W'(s)};
  endfunction

  logic        req_seen;
  logic        withhold = 1'b0;
  int unsigned busy;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fixu_ack      <= 1'b0;
      fixu_z        <= '0;
      fixu_overflow <= 1'b0;
      req_seen      <= 1'b0;
      busy          <= 0;
    end else if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        {fixu_overflow, fixu_z} <= fixu_mac(fixu_a, fixu_b, fixu_c);
        fixu_ack <= ~fixu_ack;
      end
    end else if (fixu_req != req_seen) begin
      req_seen <= fixu_req;
      if (!withhold) busy <= LAT;
    end
  end

  // Request monitor: toggle count, operand stability while pending, fn code.
  int unsigned  tgl_cnt  = 0;
  int unsigned  stab_err = 0;
  int unsigned  fn_err   = 0;
  logic         mon_req  = 1'b0;
  logic [W-1:0] la, lb, lc;
  always @(negedge clk) begin
    if (!rstn) begin
      mon_req = 1'b0;
    end else begin
      if (fixu_fn !== FN_MAC) fn_err++;
      if (fixu_req !== mon_req) begin
        mon_req = fixu_req;
        tgl_cnt++;
        la = fixu_a; lb = fixu_b; lc = fixu_c;
      end else if (fixu_req !== fixu_ack &&
                   (fixu_a !== la || fixu_b !== lb || fixu_c !== lc)) begin
        stab_err++;
      end
    end
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_coef(input logic [AW-1:0] addr, input logic [W-1:0] val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr;
    bus.coef_wdata = val;
    @(negedge clk);
    bus.coef_we    = 1'b0;
  endtask

  task automatic load_all(input logic [W-1:0] h0, h1, h2, h3);
    load_coef(2'd0, h0);
    load_coef(2'd1, h1);
    load_coef(2'd2, h2);
    load_coef(2'd3, h3);
  endtask

  task automatic send(input string tag, input logic [W-1:0] d);
    int unsigned t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [W-1:0] exp, input logic exp_ovf,
                      input int unsigned lim);
    int unsigned t = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && t < lim) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
    check_eq({tag, "_data"}, bus.out_data, exp);
    check_eq({tag, "_ovf"}, bus.out_ovf, exp_ovf);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_sample(input string tag, input logic [W-1:0] d,
                            input logic [W-1:0] exp, input logic exp_ovf);
    int unsigned t0;
    t0 = tgl_cnt;
    send(tag, d);
    recv(tag, exp, exp_ovf, 300);
    check_eq({tag, "_toggles"}, tgl_cnt - t0, TAPS);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_in_ready"},   bus.in_ready,   1'b0);
    check_eq({tag, "_coef_ready"}, bus.coef_ready, 1'b0);
    check_eq({tag, "_out_valid"},  bus.out_valid,  1'b0);
    check_eq({tag, "_out_data"},   bus.out_data,   '0);
    check_eq({tag, "_out_ovf"},    bus.out_ovf,    1'b0);
    check_eq({tag, "_req"},        fixu_req,       1'b0);
    check_eq({tag, "_a"},          fixu_a,         '0);
    check_eq({tag, "_c"},          fixu_c,         '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] imp_x [4];
    logic [W-1:0] imp_y [4];
    int unsigned  t, t0, bad;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;

    repeat (3) @(negedge clk);
    check_idle_zero("rst");
    rstn = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready_en0", bus.in_ready, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check_eq("en_in_ready", bus.in_ready, 1'b1);
    check_eq("en_coef_ready", bus.coef_ready, 1'b1);

    // Impulse response
    load_all(FIX_ONE, FIX_ONE / 2, FIX_ONE / 4, '0);
    imp_x = '{FIX_ONE, 16'd0, 16'd0, 16'd0};
    imp_y = '{FIX_ONE, FIX_ONE / 2, FIX_ONE / 4, 16'd0};
    for (int i = 0; i < 4; i++) run_sample($sformatf("imp%0d", i), imp_x[i], imp_y[i], 1'b0);

    // Backpressure: delay line [8192,0,0,0] -> 8192; then [1000,8192,0,0] -> 5096
    t0 = tgl_cnt;
    send("bp1", 16'd8192);
    t = 0;
    while (!bus.out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("bp1_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1000;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_data !== 16'd8192 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    check_eq("bp_hold_stable", bad, 0);
    check_eq("bp_in_ready", bus.in_ready, 1'b0);
    check_eq("bp1_data", bus.out_data, 16'd8192);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("bp2_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    recv("bp2", 16'd5096, 1'b0, 300);
    check_eq("bp_toggles", tgl_cnt - t0, 2 * TAPS);

    // Coefficient write in WAIT is ignored: [0,1000,8192,0] -> 500 + 2048
    t0 = tgl_cnt;
    send("cw", 16'd0);
    t = 0;
    while (tgl_cnt == t0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("cw_coef_ready", bus.coef_ready, 1'b0);
    load_coef(2'd0, 16'd8192);
    recv("cw", 16'd2548, 1'b0, 300);
    // Same write in IDLE: h0=8192, [4096,0,1000,8192] -> 8192 + 250
    check_eq("cw2_coef_ready", bus.coef_ready, 1'b1);
    load_coef(2'd0, 16'd8192);
    run_sample("cw2", FIX_ONE, 16'd8442, 1'b0);

    // Overflow on one sample only
    load_all(16'h7fff, '0, '0, '0);
    run_sample("ovf", 16'h7fff, 16'h7fff, 1'b1);
    run_sample("ovf_next", 16'd0, 16'd0, 1'b0);

    // Reset while waiting on tap 2, then frozen for 5 cycles
    load_all(FIX_ONE, FIX_ONE / 2, FIX_ONE / 4, '0);
    t0 = tgl_cnt;
    send("mid", FIX_ONE);
    t = 0;
    while (tgl_cnt != t0 + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid_tap2_reached", tgl_cnt - t0, 3);
    rstn = 1'b0;
    @(negedge clk);
    rstn   = 1'b1;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_zero("mid_rst");
    enable = 1'b1;
    @(negedge clk);
    check_eq("mid_in_ready", bus.in_ready, 1'b1);
    load_all(FIX_ONE, FIX_ONE / 2, FIX_ONE / 4, '0);
    run_sample("post_rst", FIX_ONE, FIX_ONE, 1'b0);

    check_eq("operand_stability", stab_err, 0);
    check_eq("fn_is_mac", fn_err, 0);

`ifdef FIX_FIR_SEQ_TIMEOUT_EN
    withhold = 1'b1;
    send("tmo", FIX_ONE);
    t = 0;
    while (!tmo_err && t < 1200) begin
      @(negedge clk);
      t++;
    end
    check_eq("tmo_err_pulse", tmo_err, 1'b1);
    check_eq("tmo_valid", bus.out_valid, 1'b1);
    @(negedge clk);
    check_eq("tmo_err_clears", tmo_err, 1'b0);
    recv("tmo", 16'd0, 1'b1, 10);
    withhold = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
